// File: rtl/count9999_ctrl_pkg.sv
// Shared types for the BCD run/pause/clear counter: FSM state encoding and BCD digit constants.
package count_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/count9999_ctrl_if.sv
// Control/status bundle between the button front end (master) and the counter controller (slave).
interface count9999_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  iStart;
  logic                  iStop;
  logic                  iClear;
  logic [4*DIGITS-1:0]   oDigits;
  logic                  oRunning;
  logic                  oDone;
  logic                  oWrap;

  modport master (output iStart, iStop, iClear, input oDigits, oRunning, oDone, oWrap);
  modport slave  (input iStart, iStop, iClear, output oDigits, oRunning, oDone, oWrap);
endinterface

// File: rtl/count9999_ctrl_bcd_digit.sv
// One decade stage: counts 0..9 when enabled, synchronous clear, flags when sitting at 9.
module bcd_digit
  import count_pkg::*;
(
  input  logic             iclk,
  input  logic             irst,
  input  logic             iClr,
  input  logic             iCE,
  output logic [BCD_W-1:0] oDigit,
  output logic             oAtMax
);
  assign oAtMax = (oDigit == BCD_MAX);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst)      oDigit <= '0;
    else if (iClr) oDigit <= '0;
    else if (iCE)  oDigit <= oAtMax ? '0 : oDigit + 1'b1;
  end
endmodule

// File: rtl/count9999_ctrl.sv
// Run/pause/clear controller for a cascaded BCD counter with prescaled tick.
// COUNT9999_AUTO_RELOAD_EN: wrap 9..9 -> 0 and pulse oWrap instead of stopping in DONE.
module count9999_ctrl
  import count_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50_000_000
) (
  input  logic             iclk,
  input  logic             irst,
  count9999_ctrl_if.slave  bus
);
  localparam int            PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  state_e                        state;
  logic [PW-1:0]                 psc;
  logic                          tick, running, done;
  logic [DIGITS-1:0]             at_max, low9, ce;
  logic [DIGITS-1:0][BCD_W-1:0]  dig;

  assign tick = (state == RUN) && (psc == PMAX);

  // low9[k]: every stage below k is at 9, so a tick ripples into stage k this edge
  for (genvar k = 0; k < DIGITS; k++) begin : g_stage
    if (k == 0) begin : g_lsd
      assign low9[k] = 1'b1;
    end else begin : g_upper
      assign low9[k] = low9[k-1] & at_max[k-1];
    end
    assign ce[k] = tick & low9[k];

    bcd_digit u_digit (
      .iclk   (iclk),
      .irst   (irst),
      .iClr   (bus.iClear),
      .iCE    (ce[k]),
      .oDigit (dig[k]),
      .oAtMax (at_max[k])
    );
  end

`ifdef COUNT9999_AUTO_RELOAD_EN
  logic wrap, wrap_evt;
  assign wrap_evt = tick & low9[DIGITS-1] & at_max[DIGITS-1];
`else
  // term: this tick leaves every stage at 9 (stages that advance must be at 8)
  logic [DIGITS-1:0] nxt9;
  logic              term;
  for (genvar k = 0; k < DIGITS; k++) begin : g_term
    assign nxt9[k] = ce[k] ? (dig[k] == BCD_MAX - 4'd1) : at_max[k];
  end
  assign term = tick & (&nxt9);
`endif

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state   <= IDLE;
      psc     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
`ifdef COUNT9999_AUTO_RELOAD_EN
      wrap    <= 1'b0;
`endif
    end else begin
`ifdef COUNT9999_AUTO_RELOAD_EN
      wrap <= 1'b0;
`endif
      if (bus.iClear) begin
        state   <= IDLE;
        psc     <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (bus.iStart && !bus.iStop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            psc <= tick ? '0 : psc + 1'b1;
`ifdef COUNT9999_AUTO_RELOAD_EN
            if (wrap_evt) wrap <= 1'b1;
            if (bus.iStop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
`else
            if (term) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (bus.iStop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
`endif
          end
          default: ;  // DONE waits for clear or reset
        endcase
      end
    end
  end

  assign bus.oDigits  = dig;
  assign bus.oRunning = running;
  assign bus.oDone    = done;
`ifdef COUNT9999_AUTO_RELOAD_EN
  assign bus.oWrap    = wrap;
`else
  assign bus.oWrap    = 1'b0;
`endif
endmodule

// File: tb/tb_count9999_ctrl.sv
// Bench for count9999_ctrl (DIGITS=4, PRESCALE=4): directed scenarios plus a cycle scoreboard.
module tb_count9999_ctrl;
  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
`ifdef COUNT9999_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  count9999_ctrl_if #(.DIGITS(DIGITS)) bus ();

  count9999_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .iclk (clk),
    .irst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sb_prints = 0;

  typedef struct packed {
    logic [15:0] dig;
    logic        run;
    logic        done;
    logic        wrap;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   m_val = 0, m_psc = 0, m_st = 0;  // m_st: 0 idle, 1 run, 2 pause, 3 done
  logic m_wrap = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // Reference model: integer counter value, pushes expected outputs per edge
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_val = 0; m_psc = 0; m_st = 0; m_wrap = 1'b0;
        q.delete();
      end else begin
        m_wrap = 1'b0;
        if (bus.iClear) begin
          m_val = 0; m_psc = 0; m_st = 0;
        end else begin
          case (m_st)
            0, 2: if (bus.iStart && !bus.iStop) m_st = 1;
            1: begin
              if (m_psc == PRESCALE - 1) begin
                m_psc = 0;
                if (m_val == 9999) begin m_val = 0; m_wrap = 1'b1; end
                else m_val = m_val + 1;
                if (!AR && m_val == 9999) m_st = 3;
                else if (bus.iStop)       m_st = 2;
              end else begin
                m_psc = m_psc + 1;
                if (bus.iStop) m_st = 2;
              end
            end
            default: ;
          endcase
        end
        q.push_back({to_bcd(m_val), m_st == 1, m_st == 3, m_wrap});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && q.size() != 0) begin
        mon_e = q.pop_front();
        checks++;
        if ({bus.oDigits, bus.oRunning, bus.oDone, bus.oWrap} !== mon_e) begin
          failures++;
          if (sb_prints < 20) begin
            sb_prints++;
            $display("FAIL scoreboard t=%0t got dig=%h run=%b done=%b wrap=%b expected dig=%h run=%b done=%b wrap=%b",
                     $time, bus.oDigits, bus.oRunning, bus.oDone, bus.oWrap,
                     mon_e.dig, mon_e.run, mon_e.done, mon_e.wrap);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.oDigits, bus.oRunning, bus.oDone, bus.oWrap} !== 19'h0) begin
      failures++;
      $display("FAIL reset_outputs got dig=%h run=%b done=%b wrap=%b expected all 0",
               bus.oDigits, bus.oRunning, bus.oDone, bus.oWrap);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.oRunning !== 1'b0 || bus.oDigits !== 16'h0000) begin
      failures++;
      $display("FAIL idle_no_start got dig=%h run=%b expected 0000/0", bus.oDigits, bus.oRunning);
    end
  endtask

  task automatic test_start();
    bus.iStart = 1'b1;
    @(negedge clk); bus.iStart = 1'b0;
    checks++;
    if (bus.oRunning !== 1'b1) begin
      failures++; $display("FAIL start_running got %b expected 1", bus.oRunning);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h0000) begin
      failures++; $display("FAIL before_first_tick got %h expected 0000", bus.oDigits);
    end
    @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h0001) begin
      failures++; $display("FAIL first_tick got %h expected 0001", bus.oDigits);
    end
  endtask

  task automatic test_carry();
    for (int i = 0; i < 200 && bus.oDigits !== 16'h0009; i++) @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h0009) begin
      failures++; $display("FAIL reach_0009 got %h expected 0009", bus.oDigits);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h0010) begin
      failures++; $display("FAIL carry_0010 got %h expected 0010", bus.oDigits);
    end
    for (int i = 0; i < 5000 && bus.oDigits !== 16'h0999; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h0999) begin
      failures++; $display("FAIL hold_0999 got %h expected 0999", bus.oDigits);
    end
    @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h1000) begin
      failures++; $display("FAIL carry_1000 got %h expected 1000", bus.oDigits);
    end
  endtask

  task automatic test_pause();
    @(negedge clk); bus.iStop = 1'b1;          // prescaler is 1 here, holds at 2
    @(negedge clk); bus.iStop = 1'b0;
    checks++;
    if (bus.oRunning !== 1'b0 || bus.oDigits !== 16'h1000) begin
      failures++; $display("FAIL pause_entry got dig=%h run=%b expected 1000/0", bus.oDigits, bus.oRunning);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h1000) begin
      failures++; $display("FAIL pause_frozen got %h expected 1000", bus.oDigits);
    end
    bus.iStart = 1'b1;
    @(negedge clk); bus.iStart = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h1000 || bus.oRunning !== 1'b1) begin
      failures++; $display("FAIL resume_one_cycle got dig=%h run=%b expected 1000/1", bus.oDigits, bus.oRunning);
    end
    @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h1001) begin
      failures++; $display("FAIL resume_two_cycles got %h expected 1001", bus.oDigits);
    end
  endtask

`ifdef COUNT9999_AUTO_RELOAD_EN
  task automatic test_wrap();
    for (int i = 0; i < 40000 && bus.oDigits !== 16'h9999; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h9999 || bus.oWrap !== 1'b0) begin
      failures++; $display("FAIL hold_9999 got dig=%h wrap=%b expected 9999/0", bus.oDigits, bus.oWrap);
    end
    @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h0000 || bus.oWrap !== 1'b1 || bus.oRunning !== 1'b1 || bus.oDone !== 1'b0) begin
      failures++;
      $display("FAIL wrap_edge got dig=%h wrap=%b run=%b done=%b expected 0000/1/1/0",
               bus.oDigits, bus.oWrap, bus.oRunning, bus.oDone);
    end
    @(negedge clk);
    checks++;
    if (bus.oWrap !== 1'b0 || bus.oRunning !== 1'b1) begin
      failures++; $display("FAIL wrap_pulse_width got wrap=%b run=%b expected 0/1", bus.oWrap, bus.oRunning);
    end
  endtask
`else
  task automatic test_done();
    for (int i = 0; i < 40000 && bus.oDone !== 1'b1; i++) @(negedge clk);
    checks++;
    if (bus.oDone !== 1'b1 || bus.oRunning !== 1'b0 || bus.oDigits !== 16'h9999) begin
      failures++;
      $display("FAIL done_entry got dig=%h run=%b done=%b expected 9999/0/1", bus.oDigits, bus.oRunning, bus.oDone);
    end
    bus.iStart = 1'b1;
    repeat (40) @(negedge clk);
    bus.iStart = 1'b0;
    checks++;
    if (bus.oDigits !== 16'h9999 || bus.oDone !== 1'b1 || bus.oRunning !== 1'b0) begin
      failures++;
      $display("FAIL done_sticky got dig=%h run=%b done=%b expected 9999/0/1", bus.oDigits, bus.oRunning, bus.oDone);
    end
    bus.iClear = 1'b1;
    @(negedge clk); bus.iClear = 1'b0;
    checks++;
    if (bus.oDigits !== 16'h0000 || bus.oDone !== 1'b0 || bus.oRunning !== 1'b0) begin
      failures++;
      $display("FAIL done_clear got dig=%h run=%b done=%b expected 0000/0/0", bus.oDigits, bus.oRunning, bus.oDone);
    end
  endtask
`endif

  task automatic test_simul();
    bus.iClear = 1'b1;
    @(negedge clk); bus.iClear = 1'b0;
    bus.iStart = 1'b1;
    @(negedge clk); bus.iStart = 1'b0;
    repeat (3) @(negedge clk);
    bus.iStop = 1'b1;                          // lands on the tick edge
    @(negedge clk); bus.iStop = 1'b0;
    checks++;
    if (bus.oDigits !== 16'h0001 || bus.oRunning !== 1'b0) begin
      failures++; $display("FAIL stop_on_tick got dig=%h run=%b expected 0001/0", bus.oDigits, bus.oRunning);
    end
    bus.iStart = 1'b1;
    @(negedge clk); bus.iStart = 1'b0;
    repeat (3) @(negedge clk);
    bus.iClear = 1'b1;                         // lands on the tick edge
    @(negedge clk); bus.iClear = 1'b0;
    checks++;
    if (bus.oDigits !== 16'h0000 || bus.oRunning !== 1'b0) begin
      failures++; $display("FAIL clear_on_tick got dig=%h run=%b expected 0000/0", bus.oDigits, bus.oRunning);
    end
  endtask

  task automatic test_async_reset();
    bus.iStart = 1'b1;
    @(negedge clk); bus.iStart = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.oDigits, bus.oRunning, bus.oDone, bus.oWrap} !== 19'h0) begin
      failures++;
      $display("FAIL async_reset_immediate got dig=%h run=%b done=%b wrap=%b expected all 0",
               bus.oDigits, bus.oRunning, bus.oDone, bus.oWrap);
    end
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h0000 || bus.oRunning !== 1'b0) begin
      failures++; $display("FAIL no_auto_resume got dig=%h run=%b expected 0000/0", bus.oDigits, bus.oRunning);
    end
    bus.iStart = 1'b1;
    @(negedge clk); bus.iStart = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.oDigits !== 16'h0001 || bus.oRunning !== 1'b1) begin
      failures++; $display("FAIL restart_after_reset got dig=%h run=%b expected 0001/1", bus.oDigits, bus.oRunning);
    end
  endtask

  initial begin
    bus.iStart = 1'b0;
    bus.iStop  = 1'b0;
    bus.iClear = 1'b0;
    test_reset();
    test_start();
    test_carry();
    test_pause();
`ifdef COUNT9999_AUTO_RELOAD_EN
    test_wrap();
`else
    test_done();
`endif
    test_simul();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
